// File: rtl/dm_loader_if.sv
// dm_loader_if: bundles the loader's load stream, dump stream, data-memory port, core control and status.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the load stream, out_valid/out_ready on the dump stream.
// Modports: master = dm_loader, slave = harness side (source of load bytes, data memory, core, dump sink).
// Signals: go, in_valid/in_data/in_ready, core_reset/core_done, mem_sel/mem_wr_en/mem_addr/mem_wr_data/mem_rd_data,
//          out_valid/out_data/out_ready, busy, error, and chk when DM_LOADER_CHECKSUM_EN is defined.
interface dm_loader_if #(
   parameter int AW = 8
);
   logic          go;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          core_reset;
   logic          core_done;
   logic          mem_sel;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wr_data;
   logic [7:0]    mem_rd_data;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_ready;
   logic          busy;
   logic          error;
`ifdef DM_LOADER_CHECKSUM_EN
   logic [7:0]    chk;

   modport master (
      input  go, in_valid, in_data, core_done, mem_rd_data, out_ready,
      output in_ready, core_reset, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
      output out_valid, out_data, busy, error, chk
   );
   modport slave (
      output go, in_valid, in_data, core_done, mem_rd_data, out_ready,
      input  in_ready, core_reset, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
      input  out_valid, out_data, busy, error, chk
   );
`else
   modport master (
      input  go, in_valid, in_data, core_done, mem_rd_data, out_ready,
      output in_ready, core_reset, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
      output out_valid, out_data, busy, error
   );
   modport slave (
      output go, in_valid, in_data, core_done, mem_rd_data, out_ready,
      input  in_ready, core_reset, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
      input  out_valid, out_data, busy, error
   );
`endif
endinterface

// File: rtl/dm_loader.sv
// dm_loader: holds the core in reset, loads its data memory, runs it, then dumps a result window.
// Latency: go->in_ready 1 cycle; last load accept->core_reset low 1 cycle; core_done->first out_valid 2 cycles.
// Backpressure: in_valid low stalls LOAD with no write; out_ready low holds out_valid/out_data stable.
// Ports: clk (rising edge), reset (asynchronous, active-low), bus (dm_loader_if.master):
//   load stream in_*, dump stream out_*, data-memory port mem_* (owned by the loader unless RUN),
//   core_reset/core_done to the core, go/busy/error status.
// Optional: DM_LOADER_CHECKSUM_EN adds bus.chk, the XOR of every byte accepted during LOAD.
module dm_loader #(
   parameter int AW        = 8,
   parameter int LOAD_LEN  = 64,
   parameter int DUMP_BASE = 64,
   parameter int DUMP_LEN  = 64,
   parameter int TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   dm_loader_if.master bus
);
   localparam int            RW         = $clog2(TIMEOUT) + 1;
   localparam logic [AW-1:0] LOAD_LAST  = AW'(LOAD_LEN - 1);
   localparam logic [AW-1:0] DUMP_FIRST = AW'(DUMP_BASE);
   localparam logic [AW-1:0] DUMP_LAST  = AW'(DUMP_BASE + DUMP_LEN - 1);
   localparam logic [RW-1:0] RUN_LAST   = RW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, FINISH} state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic [RW-1:0] run_cnt;
   logic          in_ready_q;
   logic          core_reset_q;
   logic          mem_sel_q;
   logic          out_valid_q;
   logic [7:0]    out_data_q;
   logic          busy_q;
   logic          error_q;
   logic          wr_fire;

   // in_ready_q is high exactly while in LOAD, so the write strobe is a pure passthrough.
   assign wr_fire         = in_ready_q & bus.in_valid;

   assign bus.in_ready    = in_ready_q;
   assign bus.core_reset  = core_reset_q;
   assign bus.mem_sel     = mem_sel_q;
   assign bus.mem_wr_en   = wr_fire;
   assign bus.mem_wr_data = wr_fire ? bus.in_data : 8'h00;
   assign bus.mem_addr    = cnt;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.busy        = busy_q;
   assign bus.error       = error_q;

`ifdef DM_LOADER_CHECKSUM_EN
   logic [7:0] chk_q;
   assign bus.chk = chk_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         run_cnt      <= '0;
         in_ready_q   <= 1'b0;
         core_reset_q <= 1'b1;
         mem_sel_q    <= 1'b1;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'h00;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef DM_LOADER_CHECKSUM_EN
         chk_q        <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.go) begin
                  state      <= LOAD;
                  cnt        <= '0;
                  error_q    <= 1'b0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
`ifdef DM_LOADER_CHECKSUM_EN
                  chk_q      <= 8'h00;
`endif
               end
            end
            LOAD: begin
               if (wr_fire) begin
`ifdef DM_LOADER_CHECKSUM_EN
                  chk_q <= chk_q ^ bus.in_data;
`endif
                  // Counter holds on the last byte instead of stepping past the image.
                  if (cnt == LOAD_LAST) begin
                     state        <= RUN;
                     in_ready_q   <= 1'b0;
                     core_reset_q <= 1'b0;
                     mem_sel_q    <= 1'b0;
                     run_cnt      <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               run_cnt <= run_cnt + 1'b1;
               // First RUN cycle (run_cnt==0): the core is still leaving reset, its done flag is not trusted.
               // Done is tested before the timeout so a coincident done wins.
               if (bus.core_done && (run_cnt != '0)) begin
                  state        <= DUMP;
                  cnt          <= DUMP_FIRST;
                  core_reset_q <= 1'b1;
                  mem_sel_q    <= 1'b1;
               end else if (run_cnt == RUN_LAST) begin
                  state        <= FINISH;
                  error_q      <= 1'b1;
                  core_reset_q <= 1'b1;
                  mem_sel_q    <= 1'b1;
               end
            end
            DUMP: begin
               // Two-phase per byte: present cnt and capture the read, then hold until accepted.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= bus.mem_rd_data;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (cnt == DUMP_LAST) begin
                     state <= FINISH;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            FINISH: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dm_loader.sv
// tb_dm_loader: drives dm_loader through load/run/dump sequences against a byte-level reference model.
// Latency: checks go->in_ready, last accept->core_reset low and done->out_valid cycle counts.
// Backpressure: exercises in_valid stalls and out_ready holds, checking stability while held.
module tb_dm_loader;
   localparam int AW        = 8;
   localparam int LOAD_LEN  = 64;
   localparam int DUMP_BASE = 64;
   localparam int DUMP_LEN  = 64;
   localparam int TIMEOUT   = 4096;

   logic clk;
   logic reset;

   dm_loader_if #(.AW(AW)) bus ();

   dm_loader #(
      .AW(AW), .LOAD_LEN(LOAD_LEN), .DUMP_BASE(DUMP_BASE),
      .DUMP_LEN(DUMP_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: the image being loaded and the result window the "core" leaves in memory.
   logic [7:0] img     [0:255];
   logic [7:0] res_mem [0:255];
   int         wr_idx;
   int         low_cnt;
   bit         tb_load;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rd_data = res_mem[bus.mem_addr];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

`ifdef DM_LOADER_CHECKSUM_EN
   function automatic logic [7:0] img_xor();
      logic [7:0] x = 8'h00;
      for (int i = 0; i < LOAD_LEN; i++) x = x ^ img[i];
      return x;
   endfunction
`endif

   // Write monitor: during LOAD every accepted byte must land at the next address with the image byte.
   logic       prev_stall;
   logic [7:0] prev_dat;
   always @(negedge clk) begin
      if (tb_load) begin
         check_val("wr_en_vs_valid", 32'(bus.mem_wr_en), 32'(bus.in_valid));
         if (bus.mem_wr_en) begin
            check_val("wr_addr", 32'(bus.mem_addr), wr_idx);
            check_val("wr_data", 32'(bus.mem_wr_data), 32'(img[8'(wr_idx)]));
            check_val("wr_sel", 32'(bus.mem_sel), 1);
            wr_idx++;
         end
      end else begin
         check_val("no_wr", 32'(bus.mem_wr_en), 0);
      end
      if (!bus.core_reset) low_cnt++;
      if (prev_stall) begin
         check_val("hold_vld", 32'(bus.out_valid), 1);
         check_val("hold_dat", 32'(bus.out_data), 32'(prev_dat));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_dat   = bus.out_data;
   end

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_in_ready"},    32'(bus.in_ready), 0);
      check_val({tag, "_core_reset"},  32'(bus.core_reset), 1);
      check_val({tag, "_mem_sel"},     32'(bus.mem_sel), 1);
      check_val({tag, "_mem_wr_en"},   32'(bus.mem_wr_en), 0);
      check_val({tag, "_mem_addr"},    32'(bus.mem_addr), 0);
      check_val({tag, "_mem_wr_data"}, 32'(bus.mem_wr_data), 0);
      check_val({tag, "_out_valid"},   32'(bus.out_valid), 0);
      check_val({tag, "_out_data"},    32'(bus.out_data), 0);
      check_val({tag, "_busy"},        32'(bus.busy), 0);
      check_val({tag, "_error"},       32'(bus.error), 0);
`ifdef DM_LOADER_CHECKSUM_EN
      check_val({tag, "_chk"},         32'(bus.chk), 0);
`endif
   endtask

   task automatic fill_img(input bit inc);
      for (int i = 0; i < 256; i++) img[i] = inc ? 8'(i) : 8'($urandom);
   endtask

   // Called at posedge+1 while the DUT is idle.
   task automatic start_go();
      bus.go = 1'b1;
      @(posedge clk); #1;
      bus.go  = 1'b0;
      tb_load = 1'b1;
      wr_idx  = 0;
      low_cnt = 0;
   endtask

   // stall_mode: 0 always valid, 1 alternate 1/0, 2 random.
   task automatic load_bytes(input int n, input int stall_mode, input bit noise);
      int k = 0;
      int cyc = 0;
      bit v, fire;
      while (k < n && cyc < LOAD_LEN * 8 + 50) begin
         case (stall_mode)
            1:       v = (cyc % 2 == 0);
            2:       v = 1'($urandom_range(0, 1));
            default: v = 1'b1;
         endcase
         bus.in_valid = v;
         bus.in_data  = v ? img[8'(k)] : 8'($urandom);
         bus.go       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         if (cyc == 0) begin
            check_val("go_in_ready", 32'(bus.in_ready), 1);
            check_val("go_busy", 32'(bus.busy), 1);
            check_val("go_error_clr", 32'(bus.error), 0);
         end
         fire = v && bus.in_ready;
         @(posedge clk); #1;
         if (fire) k++;
         cyc++;
      end
      bus.go = 1'b0;
      check_val("load_count", k, n);
   endtask

   // d = RUN cycle in which core_done is raised (0 = never, expect timeout).
   task automatic do_run(input int stall_mode, input int bp_mode, input int d, input bit glitch, input bit noise);
      int idx, cyc, hold;
      bit r;
      start_go();
      load_bytes(LOAD_LEN, stall_mode, noise);
      check_val("load_writes", wr_idx, LOAD_LEN);
      tb_load = 1'b0;
      // Keep offering data during RUN: nothing may be written.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      for (int i = 0; i < DUMP_LEN; i++) res_mem[8'(DUMP_BASE + i)] = 8'($urandom);
      bus.core_done = glitch;
      @(negedge clk);
      check_val("run_core_reset", 32'(bus.core_reset), 0);
      check_val("run_mem_sel", 32'(bus.mem_sel), 0);
      check_val("run_in_ready", 32'(bus.in_ready), 0);
      check_val("run_busy", 32'(bus.busy), 1);
`ifdef DM_LOADER_CHECKSUM_EN
      check_val("chk_run", 32'(bus.chk), 32'(img_xor()));
`endif
      if (d > 0) begin
         for (int c = 1; c < d; c++) begin
            @(posedge clk); #1;
            bus.core_done = (c + 1 == d);
            bus.go        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         @(posedge clk); #1;
         bus.core_done = 1'b0;
         bus.go        = 1'b0;
         bus.out_ready = 1'b0;
         check_val("run_cycles", low_cnt, d);
         @(negedge clk);
         check_val("dump_lat1_vld", 32'(bus.out_valid), 0);
         check_val("dump_core_reset", 32'(bus.core_reset), 1);
         check_val("dump_addr0", 32'(bus.mem_addr), DUMP_BASE);
         check_val("dump_error", 32'(bus.error), 0);
         @(posedge clk); #1;
         idx = 0; cyc = 0; hold = 0;
         while (idx < DUMP_LEN && cyc < DUMP_LEN * 8 + 50) begin
            case (bp_mode)
               1:       r = 1'($urandom_range(0, 1));
               2:       r = !(idx == 3 && hold < 5);
               default: r = 1'b1;
            endcase
            bus.out_ready = r;
            bus.go        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (cyc == 0) check_val("dump_lat2_vld", 32'(bus.out_valid), 1);
            if (idx == 3 && bus.out_valid && !bus.out_ready) hold++;
            if (bus.out_valid && bus.out_ready) begin
               check_val("dump_dat", 32'(bus.out_data), 32'(res_mem[8'(DUMP_BASE + idx)]));
               idx++;
            end
            @(posedge clk); #1;
            cyc++;
         end
         bus.go = 1'b0;
         check_val("dump_count", idx, DUMP_LEN);
         if (bp_mode == 2) check_val("bp_cycles", hold, 5);
         @(negedge clk);
         check_val("fin_busy", 32'(bus.busy), 1);
         check_val("fin_out_valid", 32'(bus.out_valid), 0);
         check_val("fin_core_reset", 32'(bus.core_reset), 1);
         @(posedge clk); #1;
         @(negedge clk);
         check_val("idle_busy", 32'(bus.busy), 0);
         check_val("idle_error", 32'(bus.error), 0);
`ifdef DM_LOADER_CHECKSUM_EN
         check_val("chk_end", 32'(bus.chk), 32'(img_xor()));
`endif
      end else begin
         int c = 1;
         while (c < TIMEOUT + 20) begin
            @(posedge clk); #1;
            bus.core_done = 1'b0;
            bus.go        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            c++;
            @(negedge clk);
            if (bus.core_reset) break;
         end
         bus.go = 1'b0;
         check_val("to_cycles", low_cnt, TIMEOUT);
         check_val("to_error", 32'(bus.error), 1);
         check_val("to_busy", 32'(bus.busy), 1);
         check_val("to_no_dump", 32'(bus.out_valid), 0);
         check_val("to_mem_sel", 32'(bus.mem_sel), 1);
         @(posedge clk); #1;
         @(negedge clk);
         check_val("to_idle_busy", 32'(bus.busy), 0);
         check_val("to_error_sticky", 32'(bus.error), 1);
         check_val("to_out_valid", 32'(bus.out_valid), 0);
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic reset_mid_load();
      fill_img(1'b0);
      start_go();
      load_bytes(11, 0, 1'b0);
      check_val("mid_writes", wr_idx, 11);
      #2;
      tb_load      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      reset        = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.go        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.core_done = 1'b0;
      bus.out_ready = 1'b0;
      tb_load       = 1'b0;
      wr_idx        = 0;
      low_cnt       = 0;
      prev_stall    = 1'b0;
      prev_dat      = 8'h00;
      for (int i = 0; i < 256; i++) res_mem[i] = 8'($urandom);
      fill_img(1'b1);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("rst0");
      reset = 1'b1;
      @(posedge clk); #1;

      // Basic: image = address, done in RUN cycle 20, no stalls.
      fill_img(1'b1);
      do_run(0, 0, 20, 1'b0, 1'b0);
      // Input stall 1,0,1,0.
      fill_img(1'b0);
      do_run(1, 0, $urandom_range(5, 40), 1'b0, 1'b0);
      // Output backpressure on dump byte 3 for 5 cycles.
      fill_img(1'b0);
      do_run(0, 2, 10, 1'b0, 1'b0);
      // Timeout, then the next go must clear error.
      fill_img(1'b0);
      do_run(2, 1, 0, 1'b0, 1'b1);
      // Done coincides with the last RUN cycle: done wins.
      fill_img(1'b0);
      do_run(2, 1, TIMEOUT, 1'b0, 1'b0);
      // core_done pulse in the first RUN cycle must be ignored.
      fill_img(1'b0);
      do_run(2, 1, 8, 1'b1, 1'b1);
      // Reset mid-LOAD, then a fresh run starting at address 0.
      reset_mid_load();
      fill_img(1'b0);
      do_run(0, 0, 15, 1'b0, 1'b0);
      // Random mixes.
      repeat (3) begin
         fill_img(1'b0);
         do_run(2, 1, $urandom_range(3, 100), 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
